// File: rtl/cond_branch_predictor_pkg.sv
// Shared types and constants for the conditional branch predictor.
// Opcode encodings are the full 7-bit fetch opcode {opcode[6:2], opcode[1:0]}.
package cond_branch_predictor_pkg;

  typedef logic [1:0] cnt2_t;

  localparam cnt2_t CNT_SNT = 2'b00;
  localparam cnt2_t CNT_WNT = 2'b01;
  localparam cnt2_t CNT_WT  = 2'b10;
  localparam cnt2_t CNT_ST  = 2'b11;

  localparam logic [6:0] OP_BRN  = 7'b0010000;
  localparam logic [6:0] OP_CALL = 7'b0010001;
  localparam logic [6:0] OP_BREQ = 7'b0010010;
  localparam logic [6:0] OP_BRNE = 7'b0010011;
  localparam logic [6:0] OP_BRCS = 7'b0010100;
  localparam logic [6:0] OP_BRCC = 7'b0010101;

  function automatic logic is_cond_op(input logic [6:0] op);
    return (op == OP_BREQ) || (op == OP_BRNE) || (op == OP_BRCS) || (op == OP_BRCC);
  endfunction

endpackage

// File: rtl/cond_branch_predictor_sat_counter2.sv
// One 2-bit saturating up/down counter; one instance per predictor table entry.
module sat_counter2
  import cond_branch_predictor_pkg::*;
#(
  parameter cnt2_t RST_VAL = CNT_WNT
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_en,
  input  logic  i_up,
  output cnt2_t o_cnt
);

  cnt2_t r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= RST_VAL;
    end else if (i_en) begin
      if (i_up && (r_cnt != CNT_ST)) begin
        r_cnt <= r_cnt + 2'd1;
      end else if (!i_up && (r_cnt != CNT_SNT)) begin
        r_cnt <= r_cnt - 2'd1;
      end
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cond_branch_predictor.sv
// Conditional-branch predictor: 2-bit counter table read at fetch, trained at execute,
// with a registered mispredict redirect and saturating statistics.
module cond_branch_predictor
  import cond_branch_predictor_pkg::*;
#(
  parameter int    IDX_W   = 6,
  parameter cnt2_t CNT_RST = 2'b01,
  parameter int    STAT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [4:0]        CBP_OPCODE_HI_5,
  input  logic [1:0]        CBP_OPCODE_LO_2,
  input  logic [9:0]        CBP_CURR_ADDR,
  input  logic              CBP_NOP_CLR,
  output logic              CBP_PRED_TAKEN,
  input  logic              CBP_UPD_EN,
  input  logic [9:0]        CBP_UPD_ADDR,
  input  logic [9:0]        CBP_UPD_BRN_ADDR,
  input  logic              CBP_UPD_TAKEN,
  input  logic              CBP_UPD_PRED,
  output logic              CBP_MISPRED,
  output logic [9:0]        CBP_REDIRECT_ADDR,
  output logic [STAT_W-1:0] CBP_PRED_CNT,
  output logic [STAT_W-1:0] CBP_MISS_CNT
);

  localparam int N_ENT = 2 ** IDX_W;

  cnt2_t            w_cnt [N_ENT];
  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_upd_idx;
  logic [6:0]       w_op;
  logic             w_miss;
  logic             w_unused;

  logic              r_mispred;
  logic [9:0]        r_redirect;
  logic [STAT_W-1:0] r_pred_cnt;
  logic [STAT_W-1:0] r_miss_cnt;

  assign w_op      = {CBP_OPCODE_HI_5, CBP_OPCODE_LO_2};
  assign w_rd_idx  = CBP_CURR_ADDR[IDX_W-1:0];
  assign w_upd_idx = CBP_UPD_ADDR[IDX_W-1:0];
  assign w_miss    = CBP_UPD_EN && (CBP_UPD_TAKEN != CBP_UPD_PRED);
  assign w_unused  = ^{CBP_CURR_ADDR[9:IDX_W], CBP_UPD_ADDR[9:IDX_W]};

  for (genvar i = 0; i < N_ENT; i++) begin : g_ent
    sat_counter2 #(.RST_VAL(CNT_RST)) u_cnt (
      .i_clk   (CLK),
      .i_rst_n (RST_N),
      .i_en    (CBP_UPD_EN && (w_upd_idx == IDX_W'(i))),
      .i_up    (CBP_UPD_TAKEN),
      .o_cnt   (w_cnt[i])
    );
  end

  // Table read returns the registered value, so a same-cycle update is seen next cycle.
  assign CBP_PRED_TAKEN = is_cond_op(w_op) && !CBP_NOP_CLR && w_cnt[w_rd_idx][1];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_mispred  <= 1'b0;
      r_redirect <= '0;
      r_pred_cnt <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_mispred <= w_miss;
      if (w_miss) begin
        r_redirect <= CBP_UPD_TAKEN ? CBP_UPD_BRN_ADDR : CBP_UPD_ADDR + 10'd1;
      end
      if (CBP_UPD_EN && (r_pred_cnt != '1)) begin
        r_pred_cnt <= r_pred_cnt + STAT_W'(1);
      end
      if (w_miss && (r_miss_cnt != '1)) begin
        r_miss_cnt <= r_miss_cnt + STAT_W'(1);
      end
    end
  end

  assign CBP_MISPRED       = r_mispred;
  assign CBP_REDIRECT_ADDR = r_redirect;
  assign CBP_PRED_CNT      = r_pred_cnt;
  assign CBP_MISS_CNT      = r_miss_cnt;

endmodule

// File: tb/tb_cond_branch_predictor.sv
// Self-checking bench for cond_branch_predictor: scoreboard of per-update redirect and
// statistics expectations, plus inline prediction checks per scenario.
module tb_cond_branch_predictor;
  import cond_branch_predictor_pkg::*;

  localparam int STAT_W = 16;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic [4:0]        CBP_OPCODE_HI_5;
  logic [1:0]        CBP_OPCODE_LO_2;
  logic [9:0]        CBP_CURR_ADDR;
  logic              CBP_NOP_CLR;
  logic              CBP_PRED_TAKEN;
  logic              CBP_UPD_EN;
  logic [9:0]        CBP_UPD_ADDR;
  logic [9:0]        CBP_UPD_BRN_ADDR;
  logic              CBP_UPD_TAKEN;
  logic              CBP_UPD_PRED;
  logic              CBP_MISPRED;
  logic [9:0]        CBP_REDIRECT_ADDR;
  logic [STAT_W-1:0] CBP_PRED_CNT;
  logic [STAT_W-1:0] CBP_MISS_CNT;

  always #5 CLK = ~CLK;

  cond_branch_predictor #(.IDX_W(6), .CNT_RST(2'b01), .STAT_W(STAT_W)) dut (
    .CLK               (CLK),
    .RST_N             (RST_N),
    .CBP_OPCODE_HI_5   (CBP_OPCODE_HI_5),
    .CBP_OPCODE_LO_2   (CBP_OPCODE_LO_2),
    .CBP_CURR_ADDR     (CBP_CURR_ADDR),
    .CBP_NOP_CLR       (CBP_NOP_CLR),
    .CBP_PRED_TAKEN    (CBP_PRED_TAKEN),
    .CBP_UPD_EN        (CBP_UPD_EN),
    .CBP_UPD_ADDR      (CBP_UPD_ADDR),
    .CBP_UPD_BRN_ADDR  (CBP_UPD_BRN_ADDR),
    .CBP_UPD_TAKEN     (CBP_UPD_TAKEN),
    .CBP_UPD_PRED      (CBP_UPD_PRED),
    .CBP_MISPRED       (CBP_MISPRED),
    .CBP_REDIRECT_ADDR (CBP_REDIRECT_ADDR),
    .CBP_PRED_CNT      (CBP_PRED_CNT),
    .CBP_MISS_CNT      (CBP_MISS_CNT)
  );

  typedef struct packed {
    logic              mis;
    logic [9:0]        redir;
    logic [STAT_W-1:0] pc;
    logic [STAT_W-1:0] mc;
  } exp_t;

  exp_t              sb_q[$];
  exp_t              sb_e;
  int                total = 0;
  int                bad   = 0;
  logic [9:0]        m_redir;
  logic [STAT_W-1:0] m_pc;
  logic [STAT_W-1:0] m_mc;

  // Scoreboard consumer: one entry per update, due just after the edge that samples it.
  always @(posedge CLK) begin
    #1;
    if (sb_q.size() != 0) begin
      sb_e = sb_q.pop_front();
      total++; if (CBP_MISPRED !== sb_e.mis) begin bad++; $display("FAIL sb_mispred: got %0b want %0b at %0t", CBP_MISPRED, sb_e.mis, $time); end
      total++; if (CBP_REDIRECT_ADDR !== sb_e.redir) begin bad++; $display("FAIL sb_redirect: got %h want %h at %0t", CBP_REDIRECT_ADDR, sb_e.redir, $time); end
      total++; if (CBP_PRED_CNT !== sb_e.pc) begin bad++; $display("FAIL sb_pred_cnt: got %0d want %0d at %0t", CBP_PRED_CNT, sb_e.pc, $time); end
      total++; if (CBP_MISS_CNT !== sb_e.mc) begin bad++; $display("FAIL sb_miss_cnt: got %0d want %0d at %0t", CBP_MISS_CNT, sb_e.mc, $time); end
    end
  end

  task automatic upd(input logic [9:0] a, input logic [9:0] b, input logic t, input logic p);
    exp_t e;
    @(negedge CLK);
    CBP_UPD_EN = 1'b1; CBP_UPD_ADDR = a; CBP_UPD_BRN_ADDR = b;
    CBP_UPD_TAKEN = t; CBP_UPD_PRED = p;
    e.mis = (t != p);
    if (e.mis) m_redir = t ? b : a + 10'd1;
    if (m_pc != '1) m_pc = m_pc + 1'b1;
    if (e.mis && (m_mc != '1)) m_mc = m_mc + 1'b1;
    e.redir = m_redir; e.pc = m_pc; e.mc = m_mc;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge CLK);
    CBP_UPD_EN = 1'b0;
  endtask

  task automatic fetch(input logic [6:0] op, input logic [9:0] a, input logic nop);
    {CBP_OPCODE_HI_5, CBP_OPCODE_LO_2} = op;
    CBP_CURR_ADDR = a;
    CBP_NOP_CLR = nop;
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; CBP_UPD_EN = 1'b0; CBP_UPD_ADDR = '0; CBP_UPD_BRN_ADDR = '0;
    CBP_UPD_TAKEN = 1'b0; CBP_UPD_PRED = 1'b0;
    fetch(OP_BRN, 10'h000, 1'b0);
    m_redir = '0; m_pc = '0; m_mc = '0;
    repeat (2) @(posedge CLK);
    #1;
    total++; if (CBP_MISPRED !== 1'b0) begin bad++; $display("FAIL rst_mispred: got %0b want 0", CBP_MISPRED); end
    total++; if (CBP_REDIRECT_ADDR !== 10'h000) begin bad++; $display("FAIL rst_redirect: got %h want 000", CBP_REDIRECT_ADDR); end
    total++; if (CBP_PRED_CNT !== '0) begin bad++; $display("FAIL rst_pred_cnt: got %0d want 0", CBP_PRED_CNT); end
    total++; if (CBP_MISS_CNT !== '0) begin bad++; $display("FAIL rst_miss_cnt: got %0d want 0", CBP_MISS_CNT); end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_predict();
    idle();
    fetch(OP_BREQ, 10'h005, 1'b0);
    total++; if (CBP_PRED_TAKEN !== 1'b0) begin bad++; $display("FAIL init_breq: got %0b want 0", CBP_PRED_TAKEN); end
    fetch(OP_BRN, 10'h005, 1'b0);
    total++; if (CBP_PRED_TAKEN !== 1'b0) begin bad++; $display("FAIL init_brn: got %0b want 0", CBP_PRED_TAKEN); end
  endtask

  task automatic test_train();
    upd(10'h005, 10'h100, 1'b1, 1'b1);
    upd(10'h005, 10'h100, 1'b1, 1'b1);
    idle(); fetch(OP_BREQ, 10'h005, 1'b0);
    total++; if (CBP_PRED_TAKEN !== 1'b1) begin bad++; $display("FAIL train_two_taken: got %0b want 1", CBP_PRED_TAKEN); end
    repeat (4) upd(10'h005, 10'h100, 1'b1, 1'b1);
    upd(10'h005, 10'h100, 1'b0, 1'b0);
    idle(); fetch(OP_BREQ, 10'h005, 1'b0);
    total++; if (CBP_PRED_TAKEN !== 1'b1) begin bad++; $display("FAIL train_sat_hi: got %0b want 1", CBP_PRED_TAKEN); end
    upd(10'h005, 10'h100, 1'b0, 1'b0);
    idle(); fetch(OP_BREQ, 10'h005, 1'b0);
    total++; if (CBP_PRED_TAKEN !== 1'b0) begin bad++; $display("FAIL train_dec_to_01: got %0b want 0", CBP_PRED_TAKEN); end
    upd(10'h005, 10'h100, 1'b0, 1'b0);
    upd(10'h005, 10'h100, 1'b0, 1'b0);
    upd(10'h005, 10'h100, 1'b1, 1'b1);
    idle(); fetch(OP_BREQ, 10'h005, 1'b0);
    total++; if (CBP_PRED_TAKEN !== 1'b0) begin bad++; $display("FAIL train_sat_lo: got %0b want 0", CBP_PRED_TAKEN); end
    upd(10'h005, 10'h100, 1'b1, 1'b1);
    idle(); fetch(OP_BREQ, 10'h005, 1'b0);
    total++; if (CBP_PRED_TAKEN !== 1'b1) begin bad++; $display("FAIL train_recover: got %0b want 1", CBP_PRED_TAKEN); end
  endtask

  task automatic test_mispredict();
    upd(10'h005, 10'h120, 1'b1, 1'b0);
    idle();
    @(posedge CLK); #2;
    total++; if (CBP_MISPRED !== 1'b0) begin bad++; $display("FAIL mis_pulse_len: got %0b want 0", CBP_MISPRED); end
    total++; if (CBP_REDIRECT_ADDR !== 10'h120) begin bad++; $display("FAIL mis_hold: got %h want 120", CBP_REDIRECT_ADDR); end
    upd(10'h3FF, 10'h2AA, 1'b0, 1'b1);
    idle();
    @(posedge CLK); #2;
    total++; if (CBP_MISPRED !== 1'b0) begin bad++; $display("FAIL mis_wrap_len: got %0b want 0", CBP_MISPRED); end
    total++; if (CBP_REDIRECT_ADDR !== 10'h000) begin bad++; $display("FAIL mis_wrap: got %h want 000", CBP_REDIRECT_ADDR); end
  endtask

  task automatic test_back_to_back();
    upd(10'h010, 10'h0AB, 1'b1, 1'b0);
    upd(10'h011, 10'h155, 1'b0, 1'b1);
    upd(10'h020, 10'h1FF, 1'b1, 1'b1);
    idle();
  endtask

  task automatic test_reset_midop();
    upd(10'h007, 10'h000, 1'b1, 1'b1);
    upd(10'h007, 10'h000, 1'b1, 1'b1);
    upd(10'h008, 10'h000, 1'b1, 1'b1);
    upd(10'h008, 10'h000, 1'b1, 1'b1);
    idle(); fetch(OP_BRNE, 10'h007, 1'b0);
    total++; if (CBP_PRED_TAKEN !== 1'b1) begin bad++; $display("FAIL pre_rst_trained: got %0b want 1", CBP_PRED_TAKEN); end
    @(negedge CLK);
    RST_N = 1'b0;
    CBP_UPD_EN = 1'b1; CBP_UPD_ADDR = 10'h009; CBP_UPD_BRN_ADDR = 10'h333;
    CBP_UPD_TAKEN = 1'b1; CBP_UPD_PRED = 1'b0;
    @(posedge CLK); #2;
    total++; if (CBP_MISPRED !== 1'b0) begin bad++; $display("FAIL midrst_mispred: got %0b want 0", CBP_MISPRED); end
    total++; if (CBP_REDIRECT_ADDR !== 10'h000) begin bad++; $display("FAIL midrst_redirect: got %h want 000", CBP_REDIRECT_ADDR); end
    total++; if (CBP_PRED_CNT !== '0) begin bad++; $display("FAIL midrst_pred_cnt: got %0d want 0", CBP_PRED_CNT); end
    total++; if (CBP_MISS_CNT !== '0) begin bad++; $display("FAIL midrst_miss_cnt: got %0d want 0", CBP_MISS_CNT); end
    @(negedge CLK);
    RST_N = 1'b1; CBP_UPD_EN = 1'b0;
    m_redir = '0; m_pc = '0; m_mc = '0;
    fetch(OP_BREQ, 10'h007, 1'b0);
    total++; if (CBP_PRED_TAKEN !== 1'b0) begin bad++; $display("FAIL midrst_tbl7: got %0b want 0", CBP_PRED_TAKEN); end
    fetch(OP_BREQ, 10'h005, 1'b0);
    total++; if (CBP_PRED_TAKEN !== 1'b0) begin bad++; $display("FAIL midrst_tbl5: got %0b want 0", CBP_PRED_TAKEN); end
    fetch(OP_BREQ, 10'h009, 1'b0);
    total++; if (CBP_PRED_TAKEN !== 1'b0) begin bad++; $display("FAIL midrst_tbl9: got %0b want 0", CBP_PRED_TAKEN); end
    upd(10'h008, 10'h000, 1'b1, 1'b1);
    idle(); fetch(OP_BREQ, 10'h008, 1'b0);
    total++; if (CBP_PRED_TAKEN !== 1'b1) begin bad++; $display("FAIL midrst_is_01: got %0b want 1", CBP_PRED_TAKEN); end
  endtask

  task automatic test_alias();
    upd(10'h045, 10'h000, 1'b1, 1'b1);
    upd(10'h045, 10'h000, 1'b1, 1'b1);
    idle();
    fetch(OP_BREQ, 10'h005, 1'b0);
    total++; if (CBP_PRED_TAKEN !== 1'b1) begin bad++; $display("FAIL alias_breq: got %0b want 1", CBP_PRED_TAKEN); end
    fetch(OP_BRCS, 10'h005, 1'b0);
    total++; if (CBP_PRED_TAKEN !== 1'b1) begin bad++; $display("FAIL alias_brcs: got %0b want 1", CBP_PRED_TAKEN); end
    fetch(OP_BRCC, 10'h005, 1'b0);
    total++; if (CBP_PRED_TAKEN !== 1'b1) begin bad++; $display("FAIL alias_brcc: got %0b want 1", CBP_PRED_TAKEN); end
    fetch(OP_BRNE, 10'h006, 1'b0);
    total++; if (CBP_PRED_TAKEN !== 1'b0) begin bad++; $display("FAIL alias_neighbour: got %0b want 0", CBP_PRED_TAKEN); end
    fetch(OP_BRN, 10'h005, 1'b0);
    total++; if (CBP_PRED_TAKEN !== 1'b0) begin bad++; $display("FAIL alias_brn: got %0b want 0", CBP_PRED_TAKEN); end
    fetch(OP_CALL, 10'h005, 1'b0);
    total++; if (CBP_PRED_TAKEN !== 1'b0) begin bad++; $display("FAIL alias_call: got %0b want 0", CBP_PRED_TAKEN); end
    fetch(OP_BREQ, 10'h005, 1'b1);
    total++; if (CBP_PRED_TAKEN !== 1'b0) begin bad++; $display("FAIL alias_nop_clr: got %0b want 0", CBP_PRED_TAKEN); end
  endtask

  task automatic test_same_cycle();
    upd(10'h00C, 10'h000, 1'b1, 1'b1);
    fetch(OP_BREQ, 10'h00C, 1'b0);
    total++; if (CBP_PRED_TAKEN !== 1'b0) begin bad++; $display("FAIL same_cycle_old: got %0b want 0", CBP_PRED_TAKEN); end
    @(posedge CLK); #2;
    total++; if (CBP_PRED_TAKEN !== 1'b1) begin bad++; $display("FAIL same_cycle_new: got %0b want 1", CBP_PRED_TAKEN); end
    idle();
  endtask

  task automatic test_nop_update();
    upd(10'h00D, 10'h000, 1'b1, 1'b1);
    fetch(OP_BREQ, 10'h00D, 1'b1);
    upd(10'h00D, 10'h000, 1'b1, 1'b1);
    fetch(OP_BREQ, 10'h00D, 1'b1);
    idle(); #1;
    total++; if (CBP_PRED_TAKEN !== 1'b0) begin bad++; $display("FAIL nop_gate: got %0b want 0", CBP_PRED_TAKEN); end
    fetch(OP_BREQ, 10'h00D, 1'b0);
    total++; if (CBP_PRED_TAKEN !== 1'b1) begin bad++; $display("FAIL nop_upd_applied: got %0b want 1", CBP_PRED_TAKEN); end
  endtask

  task automatic test_stat_saturate();
    for (int i = 0; i < (2 ** STAT_W) + 3; i++) begin
      upd(10'(i), ~10'(i), 1'b1, 1'b0);
    end
    idle();
    @(posedge CLK); #2;
    total++; if (CBP_MISS_CNT !== {STAT_W{1'b1}}) begin bad++; $display("FAIL miss_cnt_sat: got %h want all-ones", CBP_MISS_CNT); end
    total++; if (CBP_PRED_CNT !== {STAT_W{1'b1}}) begin bad++; $display("FAIL pred_cnt_sat: got %h want all-ones", CBP_PRED_CNT); end
  endtask

  initial begin
    test_reset();
    test_predict();
    test_train();
    test_mispredict();
    test_back_to_back();
    test_reset_midop();
    test_alias();
    test_same_cycle();
    test_nop_update();
    test_stat_saturate();
    repeat (3) @(posedge CLK);
    #2;
    total++; if (sb_q.size() != 0) begin bad++; $display("FAIL sb_drain: got %0d pending want 0", sb_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
